inst_fetch: RTL and testbench

Instruction-fetch stage. Holds the PC and reads each 32-bit instruction as four byte reads over the byte-wide memory-controller port. It presents the fetched pc/inst pair to the IF/ID pipeline register. While a fetch is in flight it requests a pipeline stall from ctrl, and it redirects on jump/branch requests from EX.

---
 rtl/inst_fetch_pkg.sv | 23 ++
 rtl/inst_fetch_if.sv | 26 ++
 rtl/inst_fetch.sv | 116 +++++++++++
 tb/tb_inst_fetch.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Word and address widths, reset level and fetch FSM encodings live here.
package inst_fetch_pkg;

  localparam int ADDR_LEN = 32;
  localparam int INST_LEN = 32;

  localparam logic        RST_ACTIVE   = 1'b0;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_ISSUE = 2'd0,
    FETCH_WAIT  = 2'd1,
    FETCH_DONE  = 2'd2
  } fetch_state_e;

  // Bit offset of byte lane idx inside a little-endian word.
  function automatic logic [4:0] byte_lsb(input logic [1:0] idx);
    return {idx, 3'b000};
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Byte-wide read port between the fetch stage (master) and the memory
// controller arbiter (slave).
interface inst_fetch_if #(
  parameter int ADDR_W = 32
) ();

  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_grant;
  logic [7:0]        mem_rdata;

  modport master (
    output mem_rd,
    output mem_addr,
    input  mem_grant,
    input  mem_rdata
  );

  modport slave (
    input  mem_rd,
    input  mem_addr,
    output mem_grant,
    output mem_rdata
  );

endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: assembles each 32-bit instruction from four byte reads
// and hands the pc/inst pair to if_id, stalling the pipe while it works.
//
//   state       | meaning
//   ------------+-----------------------------------------------------
//   FETCH_ISSUE | byte request pc+idx on the bus, waiting for grant
//   FETCH_WAIT  | granted; capture returned byte into lane idx
//   FETCH_DONE  | word complete, presented to if_id until not stalled
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int               ADDR_W   = ADDR_LEN,
  parameter int               INST_W   = INST_LEN,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  inst_fetch_if.master      mem,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0] if_inst,
  output logic              if_stall_req
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [1:0]        idx_q, idx_d;
  logic [INST_W-1:0] inst_buf_q, inst_buf_d;
  logic              run;
  logic              stall_unused;

  // Only the IF hold bit matters here; the rest of the vector is for later stages.
  assign stall_unused = ^stall[5:1];
  assign run          = (rst != RST_ACTIVE);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    idx_d      = idx_q;
    inst_buf_d = inst_buf_q;
    if (jump_en) begin
      // Redirect wins over everything, including a byte landing this cycle.
      pc_d       = {jump_addr[ADDR_W-1:2], 2'b00};
      idx_d      = 2'd0;
      inst_buf_d = '0;
      state_d    = FETCH_ISSUE;
    end else begin
      unique case (state_q)
        FETCH_ISSUE: begin
          if (mem.mem_grant) state_d = FETCH_WAIT;
        end
        FETCH_WAIT: begin
          inst_buf_d[byte_lsb(idx_q) +: 8] = mem.mem_rdata;
          if (idx_q == 2'd3) begin
            idx_d   = 2'd0;
            state_d = FETCH_DONE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = FETCH_ISSUE;
          end
        end
        FETCH_DONE: begin
          if (!stall[0]) begin
            pc_d       = pc_q + ADDR_W'(4);
            inst_buf_d = '0;
            state_d    = FETCH_ISSUE;
          end
        end
        default: state_d = FETCH_ISSUE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FETCH_ISSUE;
      pc_q       <= RESET_PC;
      idx_q      <= 2'd0;
      inst_buf_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      idx_q      <= idx_d;
      inst_buf_q <= inst_buf_d;
    end
  end

  // Moore decode of the registered state; gated so reset forces every output low.
  always_comb begin
    mem.mem_rd   = 1'b0;
    mem.mem_addr = '0;
    if_pc        = '0;
    if_inst      = '0;
    if_stall_req = 1'b0;
    if (run) begin
      unique case (state_q)
        FETCH_ISSUE: begin
          mem.mem_rd   = 1'b1;
          mem.mem_addr = pc_q + ADDR_W'(idx_q);
          if_stall_req = 1'b1;
        end
        FETCH_WAIT: begin
          if_stall_req = 1'b1;
        end
        FETCH_DONE: begin
          if_pc   = pc_q;
          if_inst = inst_buf_q;
        end
        default: if_stall_req = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed latency/stall/redirect/reset scenarios, then
// a randomized run checked by a scoreboard fed from a word-level fetch model.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic [31:0] if_pc, if_inst;
  logic        if_stall_req;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic        mem_grant;

  inst_fetch_if #(.ADDR_W(32)) mem_bus ();

  inst_fetch #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .jump_en      (jump_en),
    .jump_addr    (jump_addr),
    .mem          (mem_bus),
    .if_pc        (if_pc),
    .if_inst      (if_inst),
    .if_stall_req (if_stall_req)
  );

  assign mem_rd   = mem_bus.mem_rd;
  assign mem_addr = mem_bus.mem_addr;
  assign mem_bus.mem_grant = mem_grant;

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic [7:0]  mem [1024];
  exp_t        exp_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_done = 0;
  bit          mon_en = 1'b0;
  bit          prev_done = 1'b0;
  logic [31:0] held_pc, held_inst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: an instruction is the little-endian word at its aligned pc.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mem[10'(a + 32'd3)], mem[10'(a + 32'd2)], mem[10'(a + 32'd1)], mem[10'(a)]};
  endfunction

  function automatic void predict(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.inst = mem_word(pc);
    exp_q.push_back(e);
  endfunction

  // Memory responder: a granted request returns its byte in the next cycle.
  initial begin
    bit          pend;
    logic [31:0] paddr;
    mem_bus.mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      pend  = mem_rd && mem_grant && rst;
      paddr = mem_addr;
      @(posedge clk);
      #1;
      mem_bus.mem_rdata = pend ? mem[10'(paddr)] : 8'($urandom);
    end
  end

  // Scoreboard monitor: each new DONE presentation pops one expected word.
  always @(negedge clk) begin
    exp_t e;
    bit   in_done;
    if (mon_en && rst) begin
      in_done = !if_stall_req;
      if (in_done) begin
        chk("done_no_rd", {31'b0, mem_rd}, 32'd0);
        if (!prev_done) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_empty: got pc 0x%08h, expected no presentation", if_pc);
          end else begin
            e = exp_q.pop_front();
            chk("sb_pc", if_pc, e.pc);
            chk("sb_inst", if_inst, e.inst);
            held_pc   = e.pc;
            held_inst = e.inst;
            n_done++;
            predict(e.pc + 32'd4);
          end
        end else begin
          chk("sb_hold_pc", if_pc, held_pc);
          chk("sb_hold_inst", if_inst, held_inst);
        end
      end
      prev_done = in_done;
    end
  end

  // Starts in the first ISSUE cycle of a fetch and runs it to DONE.
  task automatic fetch_check(input string nm, input logic [31:0] epc,
                             input int deny_byte, input int deny_n);
    logic [31:0] addrs [$];
    logic [31:0] eaddr [$];
    int cyc  = 0;
    int rd   = 0;
    int left = deny_n;
    while (if_stall_req && cyc < 60) begin
      if (mem_rd) begin
        addrs.push_back(mem_addr);
        rd++;
      end
      if (mem_rd && left > 0 && mem_addr == epc + 32'(deny_byte)) begin
        mem_grant = 1'b0;
        left--;
      end else begin
        mem_grant = 1'b1;
      end
      step();
      cyc++;
    end
    mem_grant = 1'b1;
    for (int b = 0; b < 4; b++)
      for (int r = 0; r < 1 + ((b == deny_byte) ? deny_n : 0); r++)
        eaddr.push_back(epc + 32'(b));
    chk({nm, "_cycles"}, 32'(cyc), 32'(8 + deny_n));
    chk({nm, "_rd_cycles"}, 32'(rd), 32'(4 + deny_n));
    chk({nm, "_n_addr"}, 32'(addrs.size()), 32'(eaddr.size()));
    for (int i = 0; i < addrs.size() && i < eaddr.size(); i++)
      chk({nm, "_addr"}, addrs[i], eaddr[i]);
    chk({nm, "_pc"}, if_pc, epc);
    chk({nm, "_inst"}, if_inst, mem_word(epc));
    chk({nm, "_stall_req"}, {31'b0, if_stall_req}, 32'd0);
    chk({nm, "_done_rd"}, {31'b0, mem_rd}, 32'd0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_rd"}, {31'b0, mem_rd}, 32'd0);
    chk({nm, "_addr"}, mem_addr, 32'd0);
    chk({nm, "_pc"}, if_pc, 32'd0);
    chk({nm, "_inst"}, if_inst, 32'd0);
    chk({nm, "_stall_req"}, {31'b0, if_stall_req}, 32'd0);
  endtask

  initial begin
    logic [31:0] tgt;
    bit          jump_prev;
    logic [31:0] tgt_prev;

    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;

    rst = 1'b0; stall = '0; jump_en = 1'b0; jump_addr = '0; mem_grant = 1'b1;
    repeat (2) step();
    chk_zero("reset");

    rst = 1'b1;
    #1;
    fetch_check("first", 32'h0, -1, 0);
    chk("first_inst_const", if_inst, 32'h0010_0513);

    step();
    fetch_check("second", 32'h4, -1, 0);

    step();
    fetch_check("deny", 32'h8, 2, 3);

    stall = 6'b000001;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_pc", if_pc, 32'h8);
      chk("stall_inst", if_inst, mem_word(32'h8));
      chk("stall_rd", {31'b0, mem_rd}, 32'd0);
      chk("stall_req", {31'b0, if_stall_req}, 32'd0);
    end
    stall = '0;
    step();
    chk("resume_rd", {31'b0, mem_rd}, 32'd1);
    chk("resume_addr", mem_addr, 32'hC);

    step(); step(); step();
    jump_en = 1'b1; jump_addr = 32'h107;
    step();
    jump_en = 1'b0;
    chk("jump_addr", mem_addr, 32'h104);
    fetch_check("jump", 32'h104, -1, 0);

    step();
    step();
    #2;
    rst = 1'b0;
    #1;
    chk_zero("async_rst");
    step();
    chk_zero("rst_hold");
    rst = 1'b1;
    #1;
    fetch_check("restart", 32'h0, -1, 0);

    // Randomized phase: scoreboard owns the checking from here on.
    held_pc   = 32'h0;
    held_inst = mem_word(32'h0);
    prev_done = 1'b1;
    exp_q.delete();
    predict(32'h4);
    mon_en    = 1'b1;
    jump_prev = 1'b0;
    tgt_prev  = '0;
    for (int c = 0; c < 4000; c++) begin
      step();
      if (jump_prev) begin
        exp_q.delete();
        predict({tgt_prev[31:2], 2'b00});
      end
      mem_grant = ($urandom % 4) != 0;
      stall     = {5'($urandom), ($urandom % 3) == 0};
      jump_prev = (c < 3960) && (($urandom % 40) == 0);
      if (jump_prev) begin
        tgt = (($urandom % 8) == 0) ? 32'hFFFF_FFF0 + ($urandom % 16) : $urandom % 1024;
        tgt_prev  = tgt;
        jump_addr = tgt;
      end
      jump_en = jump_prev;
    end
    step();
    if (jump_prev) begin
      exp_q.delete();
      predict({tgt_prev[31:2], 2'b00});
    end
    jump_en = 1'b0; mem_grant = 1'b1; stall = '0;
    repeat (40) step();
    mon_en = 1'b0;
    chk("done_count_min", 32'(n_done > 50), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
